// File: rtl/md5_pkg.sv
// Shared MD5 definitions: block geometry, padder state encoding and the
// byte-to-word mapping used by the round modules.
package md5_pkg;

    localparam int          MD5_BLK_BYTES = 64;
    localparam int          MD5_LEN_POS   = 56;
    localparam logic [7:0]  MD5_PAD_BYTE  = 8'h80;

    // Padder sequencing: collect data, append 0x80, zero fill, length, hand off.
    typedef enum logic [2:0] {
        FILL,
        PAD,
        ZERO,
        LEN,
        EMIT
    } md5_pad_state_e;

    // Word k of a 512-bit block is bytes 4k..4k+3, lowest byte least significant.
    function automatic logic [31:0] md5_word(input logic [511:0] blk, input logic [3:0] k);
        return blk[{k, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/md5_padder.sv
// MD5 message padder: turns a byte stream into 512-bit blocks carrying the
// 0x80 marker, zero fill and 64-bit little-endian bit length, with first/last
// flags for the downstream core control.
module md5_padder
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_ready
);

    localparam logic [5:0] WP_LAST = 6'(MD5_BLK_BYTES - 1);
    localparam logic [5:0] WP_LEN  = 6'(MD5_LEN_POS);

    md5_pad_state_e state, state_nxt;
    md5_pad_state_e ret, ret_nxt;
    logic           last_blk, last_nxt;

    logic [511:0]   blk_buf;
    logic [5:0]     wp;
    logic [60:0]    nbytes;
    logic           first;
    logic [63:0]    bit_len;

    assign bit_len = {nbytes, 3'b000};

    // Next-state selection; ret remembers where to resume after a block is handed off.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        ret_nxt   = ret;
        last_nxt  = last_blk;
        case (state)
            FILL: begin
                if (in_valid) begin
                    if (in_last) begin
                        // A final byte that completes the block must be emitted before padding starts.
                        if (in_keep && wp == WP_LAST) begin
                            state_nxt = EMIT;
                            ret_nxt   = PAD;
                            last_nxt  = 1'b0;
                        end else begin
                            state_nxt = PAD;
                        end
                    end else if (in_keep && wp == WP_LAST) begin
                        state_nxt = EMIT;
                        ret_nxt   = FILL;
                        last_nxt  = 1'b0;
                    end
                end
            end
            PAD: begin
                if (wp == WP_LAST) begin
                    state_nxt = EMIT;
                    ret_nxt   = ZERO;
                    last_nxt  = 1'b0;
                end else begin
                    state_nxt = ZERO;
                end
            end
            ZERO: begin
                if (wp == WP_LEN) begin
                    state_nxt = LEN;
                end else if (wp == WP_LAST) begin
                    state_nxt = EMIT;
                    ret_nxt   = ZERO;
                    last_nxt  = 1'b0;
                end
            end
            LEN: begin
                state_nxt = EMIT;
                ret_nxt   = FILL;
                last_nxt  = 1'b1;
            end
            EMIT: begin
                if (blk_ready) begin
                    state_nxt = ret;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // State register; reset abandons any message, including a held block.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= FILL;
            ret      <= FILL;
            last_blk <= 1'b0;
        end else begin
            state    <= state_nxt;
            ret      <= ret_nxt;
            last_blk <= last_nxt;
        end
    end

    // Block buffer, write pointer, byte count and first-block flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is reset because blk_data must read zero straight after reset.
            blk_buf <= '0;
            wp      <= '0;
            nbytes  <= '0;
            first   <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_keep) begin
                        blk_buf[{wp, 3'b000} +: 8] <= in_byte;
                        wp                         <= wp + 6'd1;
                        nbytes                     <= nbytes + 61'd1;
                    end
                end
                PAD: begin
                    blk_buf[{wp, 3'b000} +: 8] <= MD5_PAD_BYTE;
                    wp                         <= wp + 6'd1;
                end
                ZERO: begin
                    if (wp != WP_LEN) begin
                        blk_buf[{wp, 3'b000} +: 8] <= 8'h00;
                        wp                         <= wp + 6'd1;
                    end
                end
                LEN: begin
                    blk_buf[MD5_LEN_POS*8 +: 64] <= bit_len;
                    wp                           <= '0;
                end
                EMIT: begin
                    if (blk_ready) begin
                        first <= last_blk;
                        if (last_blk) begin
                            nbytes <= '0;
                            wp     <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == FILL);
    assign blk_valid = (state == EMIT);
    assign blk_first = blk_valid & first;
    assign blk_last  = blk_valid & last_blk;
    assign blk_data  = blk_buf;

endmodule

// File: tb/tb_md5_padder.sv
// Self-checking bench for md5_padder: directed vector table with spot bytes,
// reset corner sequences and randomized messages against a padding model.
module tb_md5_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_keep;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_first;
    logic         blk_last;
    logic         blk_ready;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        string      name;
        int         len;
        logic [7:0] base;
        bit         inc;
        bit         term;
        int         stall;
        bit         rnd;
        bit         gaps;
        int         nblk;
    } vec_t;

    typedef struct {
        int         vec;
        int         blk;
        int         pos;
        logic [7:0] val;
    } spot_t;

    blk_t         exp_q[$];
    logic [511:0] cap_q[$];
    spot_t        spots[$];
    vec_t         vecs[9];

    md5_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_spot(input int v, input int b, input int p, input logic [7:0] val);
        spot_t s;
        s.vec = v;
        s.blk = b;
        s.pos = p;
        s.val = val;
        spots.push_back(s);
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit LE bit length, cut into 64-byte blocks.
    function automatic void build_model(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nb;
        blk_t        b;
        exp_q.delete();
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            for (int i = 0; i < 64; i++) b.data[8*i +: 8] = p[64*k + i];
            b.first = (k == 0);
            b.last  = (k == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic run_msg(input logic [7:0] msg[$], input bit term, input int stall,
                           input bit rnd_stall, input bit gaps, output int got);
        int           nbeats, idx, cyc, wait_cnt, cur_stall, acc_cyc, vis_cyc, wp0;
        bit           done, seen, lat_ok;
        logic [511:0] held;
        logic         hf, hl;
        build_model(msg);
        cap_q.delete();
        nbeats    = term ? msg.size() + 1 : msg.size();
        idx       = 0;
        cyc       = 0;
        got       = 0;
        done      = 1'b0;
        seen      = 1'b0;
        wait_cnt  = 0;
        cur_stall = 0;
        acc_cyc   = -1;
        vis_cyc   = -1;
        held      = '0;
        hf        = 1'b0;
        hl        = 1'b0;
        wp0       = msg.size() % 64;
        lat_ok    = (wp0 <= 55) && !(!term && msg.size() > 0 && wp0 == 0);
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (blk_valid) begin
                if (vis_cyc < 0 && acc_cyc >= 0) vis_cyc = cyc;
                if (!seen) begin
                    seen      = 1'b1;
                    held      = blk_data;
                    hf        = blk_first;
                    hl        = blk_last;
                    wait_cnt  = 0;
                    cur_stall = rnd_stall ? int'($urandom_range(0, stall)) : stall;
                    if (got < exp_q.size()) begin
                        check($sformatf("blk%0d_data", got), blk_data, exp_q[got].data);
                        check($sformatf("blk%0d_first", got), blk_first, exp_q[got].first);
                        check($sformatf("blk%0d_last", got), blk_last, exp_q[got].last);
                    end else begin
                        check("extra_block", got + 1, exp_q.size());
                    end
                end else begin
                    check("hold_data", blk_data, held);
                    check("hold_flags", {blk_first, blk_last}, {hf, hl});
                end
                check("in_ready_in_emit", in_ready, 1'b0);
                blk_ready = (wait_cnt >= cur_stall);
                wait_cnt++;
                if (blk_ready) begin
                    cap_q.push_back(blk_data);
                    got++;
                    seen = 1'b0;
                    if (blk_last) done = 1'b1;
                end
            end else begin
                blk_ready = 1'($urandom_range(0, 1));
            end
            if (idx < nbeats) begin
                in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (idx < msg.size()) begin
                    in_byte = msg[idx];
                    in_keep = 1'b1;
                    in_last = !term && (idx == msg.size() - 1);
                end else begin
                    in_byte = 8'($urandom);
                    in_keep = 1'b0;
                    in_last = 1'b1;
                end
                if (in_valid && in_ready) begin
                    if (idx == nbeats - 1) acc_cyc = cyc;
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
                in_keep  = 1'b0;
                in_last  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_keep   = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        check("message_done", done, 1'b1);
        check("block_count", got, exp_q.size());
        if (lat_ok) check("last_block_latency", vis_cyc - acc_cyc, 59 - wp0);
    endtask

    task automatic check_after_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_blk_valid"}, blk_valid, 1'b0);
        check({tag, "_flags"}, {blk_first, blk_last}, 2'b00);
        check({tag, "_blk_data"}, blk_data, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] msg[$];
        int         got, len;
        bit         term;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_keep   = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;

        vecs[0] = '{"abc",      3,   8'h61, 1'b1, 1'b0, 0,  1'b0, 1'b0, 1};
        vecs[1] = '{"empty",    0,   8'h00, 1'b0, 1'b1, 0,  1'b0, 1'b0, 1};
        vecs[2] = '{"b55",      55,  8'h61, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1};
        vecs[3] = '{"b56",      56,  8'h61, 1'b0, 1'b0, 0,  1'b0, 1'b0, 2};
        vecs[4] = '{"b64stall", 64,  8'h30, 1'b1, 1'b0, 10, 1'b0, 1'b0, 2};
        vecs[5] = '{"b64term",  64,  8'h30, 1'b1, 1'b1, 0,  1'b0, 1'b1, 2};
        vecs[6] = '{"b63",      63,  8'h41, 1'b1, 1'b0, 2,  1'b1, 1'b1, 2};
        vecs[7] = '{"b120",     120, 8'h00, 1'b1, 1'b0, 3,  1'b1, 1'b1, 3};
        vecs[8] = '{"b128",     128, 8'hff, 1'b1, 1'b1, 1,  1'b0, 1'b0, 3};

        add_spot(0, 0, 0, 8'h61);  add_spot(0, 0, 1, 8'h62);  add_spot(0, 0, 2, 8'h63);
        add_spot(0, 0, 3, 8'h80);  add_spot(0, 0, 4, 8'h00);  add_spot(0, 0, 56, 8'h18);
        add_spot(0, 0, 57, 8'h00); add_spot(0, 0, 63, 8'h00);
        add_spot(1, 0, 0, 8'h80);  add_spot(1, 0, 1, 8'h00);  add_spot(1, 0, 56, 8'h00);
        add_spot(2, 0, 54, 8'h61); add_spot(2, 0, 55, 8'h80); add_spot(2, 0, 56, 8'hb8);
        add_spot(2, 0, 57, 8'h01);
        add_spot(3, 0, 55, 8'h61); add_spot(3, 0, 56, 8'h80); add_spot(3, 0, 57, 8'h00);
        add_spot(3, 0, 63, 8'h00); add_spot(3, 1, 0, 8'h00);  add_spot(3, 1, 55, 8'h00);
        add_spot(3, 1, 56, 8'hc0); add_spot(3, 1, 57, 8'h01);
        add_spot(4, 0, 63, 8'h6f); add_spot(4, 1, 0, 8'h80);  add_spot(4, 1, 1, 8'h00);
        add_spot(4, 1, 56, 8'h00); add_spot(4, 1, 57, 8'h02);
        add_spot(5, 1, 0, 8'h80);  add_spot(5, 1, 57, 8'h02);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_blk_valid", blk_valid, 1'b0);
        check("reset_flags", {blk_first, blk_last}, 2'b00);
        check("reset_blk_data", blk_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int v = 0; v < 9; v++) begin
            msg.delete();
            for (int i = 0; i < vecs[v].len; i++)
                msg.push_back(vecs[v].inc ? 8'(vecs[v].base + i) : vecs[v].base);
            run_msg(msg, vecs[v].term, vecs[v].stall, vecs[v].rnd, vecs[v].gaps, got);
            check({vecs[v].name, "_nblk"}, got, vecs[v].nblk);
            foreach (spots[s]) begin
                if (spots[s].vec == v) begin
                    if (spots[s].blk < cap_q.size())
                        check($sformatf("%s_b%0d_p%0d", vecs[v].name, spots[s].blk, spots[s].pos),
                              cap_q[spots[s].blk][8*spots[s].pos +: 8], spots[s].val);
                    else
                        check($sformatf("%s_b%0d_present", vecs[v].name, spots[s].blk),
                              cap_q.size(), spots[s].blk + 1);
                end
            end
        end

        // Reset while zero filling, then a clean "abc".
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = 8'(8'h61 + i);
            in_keep  = 1'b1;
            in_last  = (i == 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (8) @(negedge clk);
        check("zero_phase_not_valid", blk_valid, 1'b0);
        check_after_reset("rst_zero");
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 1'b0, 0, 1'b0, 1'b0, got);

        // Reset while a full block is held in EMIT, then a clean "abc".
        blk_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            in_keep  = 1'b1;
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4 && !blk_valid; k++) @(negedge clk);
        check("emit_reached", blk_valid, 1'b1);
        repeat (3) @(negedge clk);
        check("emit_held_in_ready", in_ready, 1'b0);
        check_after_reset("rst_emit");
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 1'b0, 0, 1'b0, 1'b0, got);

        // Randomized messages against the model.
        for (int r = 0; r < 20; r++) begin
            len = (r % 5 == 0) ? int'($urandom_range(53, 66)) : int'($urandom_range(0, 140));
            term = (len == 0) || ($urandom_range(0, 1) == 1);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            run_msg(msg, term, 3, 1'b1, 1'b1, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
